mac_seq_driver: RTL and testbench
=================================

// Module: mac_seq_driver
// PURPOSE
//  Initiator for the 8-bit signed MAC unit's valid/done interface. Holds an operand-pair buffer.
//  On start, clears the MAC, then issues LEN pairs one transaction at a time and returns the 32-bit dot product.
//  Sits between the host/control plane and one MAC unit; the MAC is the responder.
// PARAMETERS
//  DEPTH      16   operand-pair buffer entries; max vector length
//  ADDR_W     $clog2(DEPTH)  buffer address / length-index width
//  SETTLE     2    cycles waited after mac_clr falls before the first mac_valid
//  TIMEOUT    64   max cycles from mac_valid to mac_done before error
// PORTS
//  clk         in   1       clock, all logic on posedge
//  reset       in   1       synchronous, active-high reset
//  wr_en       in   1       host buffer write strobe; ignored while busy
//  wr_addr     in   ADDR_W  buffer write address
//  wr_a        in   8       signed operand A
//  wr_b        in   8       signed operand B
//  start       in   1       one-cycle request to run; ignored while busy
//  len         in   ADDR_W+1  pairs to process, latched on accepted start
//  busy        out  1       high from accepted start until result/error cycle inclusive
//  result      out  32      signed dot product, held until next accepted start
//  result_vld  out  1       one-cycle pulse when result is updated
//  err         out  1       one-cycle pulse on bad len or MAC timeout
//  mac_clr     out  1       drives the MAC reset; clears its accumulator
//  mac_valid   out  1       one-cycle transaction request to the MAC
//  mac_a       out  8       signed A to MAC
//  mac_b       out  8       signed B to MAC
//  mac_done    in   1       MAC completion pulse
//  mac_y       in   32      MAC accumulator; valid the cycle after mac_done
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx=0, result=0. Buffer contents are not reset.
//  A reset mid-run aborts the run: no result_vld, no err.
//  FSM: IDLE -> CLEAR -> SETTLE -> ISSUE -> WAIT -> (ISSUE | CAPTURE) -> IDLE; ERROR -> IDLE.
//  IDLE: on start, latch len and go to CLEAR.
//   If len==0 or len>DEPTH, go to ERROR instead; no MAC activity occurs.
//  CLEAR: mac_clr=1 for exactly 1 cycle; idx=0.
//  SETTLE: mac_clr=0 for SETTLE cycles.
//  ISSUE: mac_a/mac_b <= buf[idx]; mac_valid=1 for exactly 1 cycle; watchdog=0.
//  WAIT: mac_a/mac_b held stable until mac_done; watchdog increments.
//   On mac_done, idx++. If idx==len-1 go to CAPTURE, else go to ISSUE on the next cycle.
//   If watchdog reaches TIMEOUT without mac_done, go to ERROR.
//  CAPTURE: 1-cycle wait; then result<=mac_y, result_vld=1, return to IDLE.
//  ERROR: err=1 for 1 cycle, result unchanged, return to IDLE.
//  busy is 0 only in IDLE. start/wr_en while busy are dropped, with no queueing.
//  Write and start in the same IDLE cycle: the write lands first, so the run sees the new data.
//  mac_done seen outside WAIT is ignored. Only one outstanding MAC transaction at a time.
//  Arithmetic is done in the MAC; result is mac_y verbatim. 32-bit wrap, no overflow flag.
//  Min latency per pair: ISSUE 1 + MAC turnaround. Total = 1 + 1 + SETTLE + sum(pair) + 1 cycles.
// TESTING
//  1. Write (3,4),(-2,5),(7,-1); start len=3 -> 3 mac_valid pulses, result=-5, one result_vld, err=0.
//  2. Extremes: 16 pairs of (-128,-128), len=16 -> result=262144; then (127,-128)x16 -> result=-260096.
//  3. start len=0, then len=17 -> err pulse each time, no mac_valid/mac_clr, result unchanged.
//  4. MAC model withholds mac_done -> err pulse exactly TIMEOUT cycles after mac_valid, back to IDLE.
//  5. start and wr_en pulsed while busy -> no effect on the current run; buffer unchanged.
//  6. reset asserted mid-WAIT -> all outputs 0 next cycle; a new run gives the correct fresh result.

Source files
------------

// File: rtl/mac_seq_driver_if.sv
// mac_seq_driver_if
//   Valid/done link between the sequencing driver (master) and one
//   8-bit signed MAC unit (slave).
//   mac_clr    master->slave  clears the MAC accumulator
//   mac_valid  master->slave  one-cycle transaction request
//   mac_a      master->slave  signed operand A
//   mac_b      master->slave  signed operand B
//   mac_done   slave->master  completion pulse
//   mac_y      slave->master  accumulator, valid the cycle after mac_done
interface mac_seq_driver_if;
  logic               mac_clr;
  logic               mac_valid;
  logic signed [7:0]  mac_a;
  logic signed [7:0]  mac_b;
  logic               mac_done;
  logic signed [31:0] mac_y;

  modport master (
    output mac_clr, mac_valid, mac_a, mac_b,
    input  mac_done, mac_y
  );

  modport slave (
    input  mac_clr, mac_valid, mac_a, mac_b,
    output mac_done, mac_y
  );
endinterface

// File: rtl/mac_seq_driver.sv
// mac_seq_driver
//   Host-loaded operand-pair buffer plus a sequencer that clears a MAC unit,
//   feeds it len pairs one transaction at a time and returns the 32-bit
//   dot product the MAC accumulates.
//   clk, reset        clock, synchronous active-high reset
//   wr_en/wr_addr     host buffer write (dropped while busy)
//   wr_a/wr_b         signed operand pair written to the buffer
//   start/len         run request and pair count (dropped while busy)
//   busy              high from accepted start through the result/error cycle
//   result/result_vld dot product and its one-cycle update pulse
//   err               one-cycle pulse on bad len or MAC timeout
//   mac               master side of the MAC valid/done link
module mac_seq_driver #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic signed [7:0]   wr_a,
  input  logic signed [7:0]   wr_b,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic signed [31:0]  result,
  output logic                result_vld,
  output logic                err,
  mac_seq_driver_if.master    mac
);

  // SETTLE of 0 still spends one cycle in the settle state.
  localparam int ST_W        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int WD_W        = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_ISSUE, S_WAIT, S_CAPTURE, S_ERROR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     len_q;
  logic [ST_W-1:0]     settle_cnt;
  logic [WD_W-1:0]     wd;
  logic signed [7:0]   pair_a [DEPTH];
  logic signed [7:0]   pair_b [DEPTH];
  logic                host_ok;
  logic                last_pair;

  // The result cycle is spent in IDLE with busy still high, so host
  // requests are only taken once busy has dropped.
  assign host_ok   = (state == S_IDLE) && !busy;
  assign last_pair = ({1'b0, idx} == (len_q - 1'b1));

  // Buffer is data storage only; it keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en && host_ok) begin
      pair_a[wr_addr] <= wr_a;
      pair_b[wr_addr] <= wr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      result        <= '0;
      result_vld    <= 1'b0;
      err           <= 1'b0;
      mac.mac_clr   <= 1'b0;
      mac.mac_valid <= 1'b0;
      mac.mac_a     <= '0;
      mac.mac_b     <= '0;
      idx           <= '0;
      len_q         <= '0;
      settle_cnt    <= '0;
      wd            <= '0;
    end else begin
      result_vld    <= 1'b0;
      err           <= 1'b0;
      mac.mac_clr   <= 1'b0;
      mac.mac_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && host_ok) begin
            len_q <= len;
            busy  <= 1'b1;
            if ((len == '0) || (len > LEN_MAX)) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              state       <= S_CLEAR;
              mac.mac_clr <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          idx        <= '0;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == ST_W'(SETTLE_LAST)) begin
            mac.mac_a     <= pair_a[idx];
            mac.mac_b     <= pair_b[idx];
            mac.mac_valid <= 1'b1;
            state         <= S_ISSUE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          // wd counts cycles since mac_valid, so the ERROR cycle lands
          // exactly TIMEOUT cycles after the request.
          wd    <= WD_W'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mac.mac_done) begin
            idx <= idx + 1'b1;
            if (last_pair) begin
              state <= S_CAPTURE;
            end else begin
              mac.mac_a     <= pair_a[idx + 1'b1];
              mac.mac_b     <= pair_b[idx + 1'b1];
              mac.mac_valid <= 1'b1;
              state         <= S_ISSUE;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CAPTURE: begin
          // mac_y becomes valid the cycle after mac_done, i.e. now.
          result     <= mac.mac_y;
          result_vld <= 1'b1;
          state      <= S_IDLE;
        end
        S_ERROR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_driver.sv
// tb_mac_seq_driver
//   Directed bench for mac_seq_driver with a behavioural MAC responder.
//   Expected run outcomes are queued as runs are issued; a monitor thread
//   pops one entry per result_vld/err pulse and compares it.
`timescale 1ns/1ps
module tb_mac_seq_driver;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic signed [7:0]   wr_a;
  logic signed [7:0]   wr_b;
  logic                start;
  logic [ADDR_W:0]     len;
  logic                busy;
  logic signed [31:0]  result;
  logic                result_vld;
  logic                err;

  mac_seq_driver_if mac_bus ();

  mac_seq_driver #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .len(len),
    .busy(busy), .result(result), .result_vld(result_vld), .err(err),
    .mac(mac_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // MAC responder: mac_done arrives 'turn' cycles after mac_valid,
  // mac_y follows one cycle after mac_done.
  int                 turn;
  logic               hold_done;
  int                 cd = 0;
  logic               done_q = 1'b0;
  logic signed [31:0] acc = 0;
  logic signed [7:0]  pa, pb;
  int                 nvalid = 0;
  int                 nclr = 0;
  int                 valid_cyc = 0;

  always @(negedge clk) begin
    if (done_q) mac_bus.mac_y = acc;
    mac_bus.mac_done = 1'b0;
    done_q = 1'b0;
    if (mac_bus.mac_clr) begin
      acc = 0;
      cd  = 0;
      nclr++;
    end else if (mac_bus.mac_valid) begin
      pa = mac_bus.mac_a;
      pb = mac_bus.mac_b;
      cd = turn;
      nvalid++;
      valid_cyc = cyc;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !hold_done) begin
        acc = acc + pa * pb;
        mac_bus.mac_done = 1'b1;
        done_q = 1'b1;
      end
    end
  end

  typedef struct {
    logic   is_err;
    longint value;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   evt_cnt = 0;
  int   err_cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input longint value);
    exp_t e;
    e.is_err = is_err;
    e.value  = value;
    sb_q.push_back(e);
  endtask

  task automatic wr(input int addr, input int a, input int b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_a = 8'(a); wr_b = 8'(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int l);
    @(negedge clk);
    start = 1'b1; len = 5'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_for(input int e0, input string nm);
    int n;
    n = 0;
    while (evt_cnt == e0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (evt_cnt == e0) begin
      checks++;
      errors++;
      $display("FAIL %s: no result_vld/err within 400 cycles", nm);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input int l, input string nm);
    int e0;
    e0 = evt_cnt;
    start_run(l);
    wait_for(e0, nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nv, nc, e0, n;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; len = '0; turn = 2; hold_done = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (result_vld || err) begin
          if (err) err_cyc = cyc;
          evt_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: err=%0d result=%0d, none expected", err, result);
          end else begin
            mon_e = sb_q.pop_front();
            check("event_kind_err", longint'(err), longint'(mon_e.is_err));
            check("event_result", longint'(result), mon_e.value);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", longint'({busy, result_vld, err, mac_bus.mac_clr, mac_bus.mac_valid}), 0);
    check("rst_result", longint'(result), 0);
    check("rst_operands", longint'({mac_bus.mac_a, mac_bus.mac_b}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: three pairs, last pair written in the same cycle as start
    wr(0, 3, 4);
    wr(1, -2, 5);
    push_exp(1'b0, -5);
    nv = nvalid; nc = nclr; e0 = evt_cnt;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd2; wr_a = 8'sd7; wr_b = -8'sd1;
    start = 1'b1; len = 5'd3;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_for(e0, "t1_run");
    check("t1_mac_valid_count", nvalid - nv, 3);
    check("t1_mac_clr_count", nclr - nc, 1);

    // Test 2: extreme operands across the full depth
    turn = 1;
    for (int i = 0; i < DEPTH; i++) wr(i, -128, -128);
    push_exp(1'b0, 262144);
    nv = nvalid;
    do_run(16, "t2_neg_neg");
    check("t2_mac_valid_count", nvalid - nv, 16);
    for (int i = 0; i < DEPTH; i++) wr(i, 127, -128);
    push_exp(1'b0, -260096);
    do_run(16, "t2_pos_neg");

    // Test 3: bad lengths
    turn = 2;
    nv = nvalid; nc = nclr;
    push_exp(1'b1, -260096);
    do_run(0, "t3_len0");
    push_exp(1'b1, -260096);
    do_run(17, "t3_len17");
    check("t3_mac_valid_count", nvalid - nv, 0);
    check("t3_mac_clr_count", nclr - nc, 0);

    // Test 4: MAC never answers
    hold_done = 1'b1;
    push_exp(1'b1, -260096);
    do_run(1, "t4_timeout");
    check("t4_timeout_latency", err_cyc - valid_cyc, TIMEOUT);
    check("t4_busy_after", longint'(busy), 0);
    hold_done = 1'b0;

    // Test 5: host traffic while busy is dropped
    wr(0, 1, 1);
    wr(1, 2, 2);
    wr(2, 3, 3);
    push_exp(1'b0, 14);
    e0 = evt_cnt;
    start_run(3);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_a = 8'sd100; wr_b = 8'sd100;
    start = 1'b1; len = 5'd1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_for(e0, "t5_busy_run");
    push_exp(1'b0, 14);
    do_run(3, "t5_rerun");

    // Test 6: reset in the middle of a MAC wait
    wr(0, 1, 2);
    wr(1, 3, 4);
    wr(2, 5, 6);
    nv = nvalid;
    start_run(3);
    n = 0;
    while (nvalid == nv && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_valid_seen", longint'(nvalid - nv), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ctrl", longint'({busy, result_vld, err, mac_bus.mac_clr, mac_bus.mac_valid}), 0);
    check("t6_rst_result", longint'(result), 0);
    check("t6_rst_operands", longint'({mac_bus.mac_a, mac_bus.mac_b}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_exp(1'b0, 44);
    do_run(3, "t6_fresh_run");

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
